fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the core's decode stage.
- Drives the memory address/control bus for opcode fetches and captures instruction words from D.
- Buffers fetched instructions in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Handles ARM/Thumb step size, branch redirect with queue flush, nWAIT stalls, and prefetch-abort tagging.

Parameters:
- QDEPTH, 2: prefetch queue entries (power of two, >=2).
- RESET_VECTOR, 32'h00000000: first fetch address after reset.

Ports:
- mclk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- nWAIT  input  1  low = memory not ready; current bus cycle is extended.
- tbit  input  1  1 = Thumb state (halfword fetch), 0 = ARM (word fetch).
- branchValid  input  1  redirect request from execute.
- branchTarget  input  32  redirect address.
- D  input  32  instruction read data.
- abort  input  1  prefetch abort for the current fetch, sampled with D.
- decodeReady  input  1  decode accepts the head entry this cycle.
- A  output  32  fetch address.
- nMREQ  output  1  0 = memory request this cycle.
- seq  output  1  1 = A is sequential to the previous fetch.
- mas  output  2  access size: 2'b10 word (ARM), 2'b01 halfword (Thumb).
- nOPC  output  1  equals nMREQ (every request is an opcode fetch).
- instrValid  output  1  queue head valid.
- instrData  output  32  head instruction; Thumb halfword is zero-extended.
- instrPC  output  32  address the head instruction was fetched from.
- instrAbort  output  1  head entry carries a prefetch abort.

Behaviour:
- **Reset.** While reset is high:
  - A=RESET_VECTOR, nMREQ=1, nOPC=1, seq=0.
  - Queue is empty; instrValid=0, instrData=0, instrPC=0, instrAbort=0.
  - Pending redirect is cleared.
  - Reset mid-fetch discards the in-flight fetch.
  - First cycle after reset: nMREQ=0, A=RESET_VECTOR, seq=0.
- **Request rule.** nMREQ=0 iff queue count < QDEPTH, or count == QDEPTH and a pop occurs this cycle.
- **Fetch completion.** A fetch completes at a rising edge where nMREQ=0 and nWAIT=1.
  - D, abort and A are pushed into the queue.
  - A advances by 4 (tbit=0) or 2 (tbit=1), wrapping modulo 2^32.
- **Wait state.** If nWAIT=0, then A, nMREQ, seq and mas are held stable and nothing is pushed.
- **Thumb data select.** A[1]=0 selects D[15:0]; A[1]=1 selects D[31:16]; upper 16 bits are zero.
- **Mode size.** mas is combinational from tbit. tbit may change only in a cycle with branchValid=1.
- **Sequential flag.** seq=1 iff the previous cycle completed a fetch (nMREQ=0, nWAIT=1) and no redirect was applied at that edge. Otherwise seq=0: after reset, after a redirect, after an idle cycle, or on the first cycle of an access that follows a stall.
- **Pop.** A pop occurs when instrValid=1 and decodeReady=1.
  - Push and pop in the same cycle leave the count unchanged.
  - Order is strictly FIFO.
- **Redirect, nWAIT=1.** At an edge with branchValid=1 and nWAIT=1:
  - The queue is flushed; instrValid=0 next cycle.
  - Any fetch completing at that edge is discarded.
  - A <= branchTarget with [1:0] cleared (ARM) or [0] cleared (Thumb), using the new tbit. seq=0 for that fetch.
- **Redirect, nWAIT=0.** branchValid with nWAIT=0 latches target and mode into a pending register and flushes the queue immediately. The bus stays frozen. At the first edge with nWAIT=1, the in-flight data is discarded and A loads the pending target.
  - A newer branchValid overwrites the pending target.
  - reset clears the pending register.
- **Abort.** An aborted fetch is queued normally with instrAbort=1, and fetching continues. Decode/execute decide whether it is taken.
- **Queue boundaries.**
  - Full with no pop: nMREQ=1; A is held and will be re-requested with seq=0.
  - Empty: outputs show zeros with instrValid=0.
  - Pointers wrap modulo QDEPTH.

Test Plan:
- **Reset then ARM fetch.** Release reset, tbit=0, nWAIT=1, decodeReady=1, D=word at address. Expect A = 0,4,8,… with seq=0,1,1; mas=2'b10. instrPC=0 and instrData=D(0) appear one cycle after the first fetch.
- **Backpressure.** decodeReady=0 from the start. Expect 2 pushes (A=0,4), then nMREQ=1 with A=8 held. On decodeReady=1, nMREQ=0 in the same cycle, then A=8 fetched with seq=0.
- **Wait states.** nWAIT=0 for 3 cycles at A=0x10. Expect A, mas and nMREQ stable; nothing pushed; then 0x10 is pushed once and A=0x14.
- **Thumb halfwords.** Branch to 0x102 with tbit=1, D=32'hAAAA_BBBB. Expect instrData=32'h0000_AAAA at PC 0x102; next fetch A=0x104, mas=2'b01, seq=1.
- **Redirect during wait.** branchValid with target 0x200 while nWAIT=0 and the queue holds 2 entries. Expect instrValid=0 next cycle; bus frozen until nWAIT=1; old data discarded; then A=0x200 with seq=0.
- **Abort and wrap.** Fetch at 0xFFFFFFFC with abort=1. Expect instrAbort=1 and instrPC=0xFFFFFFFC; next A=0x00000000 with seq=1.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: drives opcode fetches on the memory bus and feeds
// decode from a small prefetch FIFO with redirect, stall and abort handling.
module fetch_prefetch_unit #(
    parameter int          QDEPTH       = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        nWAIT,
    input  logic        tbit,
    input  logic        branchValid,
    input  logic [31:0] branchTarget,
    input  logic [31:0] D,
    input  logic        abort,
    input  logic        decodeReady,
    output logic [31:0] A,
    output logic        nMREQ,
    output logic        seq,
    output logic [1:0]  mas,
    output logic        nOPC,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPC,
    output logic        instrAbort
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] QFULL = (PW + 1)'(QDEPTH);

    logic [31:0]       a_r;
    logic              seq_r;
    logic              pend_valid_r;
    logic [31:0]       pend_target_r;
    logic [31:0]       q_data_r [QDEPTH];
    logic [31:0]       q_pc_r   [QDEPTH];
    logic [QDEPTH-1:0] q_abort_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW:0]       count_r;

    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        req_s;
    logic        fetch_done_s;
    logic        redirect_now_s;
    logic        push_s;
    logic        flush_s;
    logic [31:0] step_s;
    logic [31:0] fetch_data_s;
    logic [31:0] branch_aligned_s;
    logic [31:0] redirect_target_s;

    // Handshake, request and redirect decisions for the current cycle
    always_comb begin
        empty_s        = (count_r == '0);
        full_s         = (count_r == QFULL);
        pop_s          = !reset && !empty_s && decodeReady;
        req_s          = !reset && (!full_s || pop_s);
        fetch_done_s   = req_s && nWAIT;
        // A pending redirect is applied at the first edge the bus is not stalled
        redirect_now_s = !reset && nWAIT && (branchValid || pend_valid_r);
        push_s         = fetch_done_s && !redirect_now_s;
        flush_s        = branchValid || redirect_now_s;
        step_s         = tbit ? 32'd2 : 32'd4;
        if (tbit) begin
            branch_aligned_s = {branchTarget[31:1], 1'b0};
        end else begin
            branch_aligned_s = {branchTarget[31:2], 2'b00};
        end
        if (branchValid) begin
            redirect_target_s = branch_aligned_s;
        end else begin
            redirect_target_s = pend_target_r;
        end
    end

    // Thumb fetches pick the addressed halfword and zero-extend it
    always_comb begin
        fetch_data_s = D;
        if (!tbit) begin
            fetch_data_s = D;
        end else if (a_r[1]) begin
            fetch_data_s = {16'h0000, D[31:16]};
        end else begin
            fetch_data_s = {16'h0000, D[15:0]};
        end
    end

    // Fetch address and sequential flag; both freeze during a wait state
    always_ff @(posedge mclk) begin
        if (reset) begin
            a_r   <= RESET_VECTOR;
            seq_r <= 1'b0;
        end else if (redirect_now_s) begin
            a_r   <= redirect_target_s;
            seq_r <= 1'b0;
        end else if (fetch_done_s) begin
            a_r   <= a_r + step_s;
            seq_r <= 1'b1;
        end else if (req_s) begin
            a_r   <= a_r;
            seq_r <= seq_r;
        end else begin
            a_r   <= a_r;
            seq_r <= 1'b0;
        end
    end

    // Redirect that arrived while the bus was stalled
    always_ff @(posedge mclk) begin
        if (reset) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
        end else if (branchValid && !nWAIT) begin
            pend_valid_r  <= 1'b1;
            pend_target_r <= branch_aligned_s;
        end else if (redirect_now_s) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= pend_target_r;
        end else begin
            pend_valid_r  <= pend_valid_r;
            pend_target_r <= pend_target_r;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge mclk) begin
        if (reset || flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; stale contents are masked by the occupancy count
    always_ff @(posedge mclk) begin
        if (push_s) begin
            q_data_r[wr_ptr_r]  <= fetch_data_s;
            q_pc_r[wr_ptr_r]    <= a_r;
            q_abort_r[wr_ptr_r] <= abort;
        end else begin
            q_abort_r <= q_abort_r;
        end
    end

    // Bus and decode-side outputs
    always_comb begin
        nMREQ = !req_s;
        nOPC  = !req_s;
        mas   = tbit ? 2'b01 : 2'b10;
        if (reset) begin
            A   = RESET_VECTOR;
            seq = 1'b0;
        end else begin
            A   = a_r;
            seq = seq_r;
        end
        instrValid = !reset && !empty_s;
        if (instrValid) begin
            instrData  = q_data_r[rd_ptr_r];
            instrPC    = q_pc_r[rd_ptr_r];
            instrAbort = q_abort_r[rd_ptr_r];
        end else begin
            instrData  = 32'h0000_0000;
            instrPC    = 32'h0000_0000;
            instrAbort = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: ARM/Thumb fetch, backpressure,
// wait states, redirects (normal and during a stall), abort and wrap.
module tb_fetch_prefetch_unit;

    logic        mclk = 1'b0;
    logic        reset;
    logic        nWAIT;
    logic        tbit;
    logic        branchValid;
    logic [31:0] branchTarget;
    logic [31:0] D;
    logic        abort;
    logic        decodeReady;
    logic [31:0] A;
    logic        nMREQ;
    logic        seq;
    logic [1:0]  mas;
    logic        nOPC;
    logic        instrValid;
    logic [31:0] instrData;
    logic [31:0] instrPC;
    logic        instrAbort;

    logic        use_fixed;
    logic [31:0] d_fixed;
    int          n_total = 0;
    int          n_bad   = 0;

    fetch_prefetch_unit #(.QDEPTH(2), .RESET_VECTOR(32'h0000_0000)) dut (
        .mclk(mclk), .reset(reset), .nWAIT(nWAIT), .tbit(tbit),
        .branchValid(branchValid), .branchTarget(branchTarget), .D(D),
        .abort(abort), .decodeReady(decodeReady), .A(A), .nMREQ(nMREQ),
        .seq(seq), .mas(mas), .nOPC(nOPC), .instrValid(instrValid),
        .instrData(instrData), .instrPC(instrPC), .instrAbort(instrAbort)
    );

    // Clock
    always #5 mclk = ~mclk;

    // Memory model: every word reads as its address xor a fixed pattern
    assign D = use_fixed ? d_fixed : (A ^ 32'h1234_5678);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; nWAIT = 1'b1; tbit = 1'b0; branchValid = 1'b0;
        branchTarget = 32'h0; abort = 1'b0; decodeReady = 1'b1;
        use_fixed = 1'b0; d_fixed = 32'h0;

        // Reset values
        tick(); tick();
        check_val("rst_A", A, 32'h0);
        check_val("rst_nMREQ", {31'h0, nMREQ}, 32'h1);
        check_val("rst_nOPC", {31'h0, nOPC}, 32'h1);
        check_val("rst_seq", {31'h0, seq}, 32'h0);
        check_val("rst_valid", {31'h0, instrValid}, 32'h0);
        check_val("rst_data", instrData, 32'h0);

        // ARM fetch after reset
        reset = 1'b0;
        #1;
        check_val("arm_first_nMREQ", {31'h0, nMREQ}, 32'h0);
        check_val("arm_first_A", A, 32'h0);
        check_val("arm_first_seq", {31'h0, seq}, 32'h0);
        check_val("arm_mas", {30'h0, mas}, 32'h2);
        tick();
        check_val("arm_A4", A, 32'h4);
        check_val("arm_seq1", {31'h0, seq}, 32'h1);
        check_val("arm_pc0", instrPC, 32'h0);
        check_val("arm_d0", instrData, 32'h1234_5678);
        tick();
        check_val("arm_A8", A, 32'h8);
        check_val("arm_pc4", instrPC, 32'h4);
        check_val("arm_d4", instrData, 32'h1234_567C);

        // Backpressure
        decodeReady = 1'b0;
        do_reset();
        tick(); tick();
        check_val("bp_full_nMREQ", {31'h0, nMREQ}, 32'h1);
        check_val("bp_full_A", A, 32'h8);
        tick();
        check_val("bp_hold_A", A, 32'h8);
        check_val("bp_hold_seq", {31'h0, seq}, 32'h0);
        check_val("bp_hold_pc", instrPC, 32'h0);
        decodeReady = 1'b1;
        #1;
        check_val("bp_pop_nMREQ", {31'h0, nMREQ}, 32'h0);
        tick();
        check_val("bp_pc4", instrPC, 32'h4);
        check_val("bp_AC", A, 32'hC);
        check_val("bp_seq", {31'h0, seq}, 32'h1);
        tick();
        check_val("bp_pc8", instrPC, 32'h8);
        check_val("bp_d8", instrData, 32'h1234_5670);

        // Wait states at 0x10
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        check_val("ws_A10", A, 32'h10);
        nWAIT = 1'b0;
        decodeReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("ws_hold_A", A, 32'h10);
            check_val("ws_hold_nMREQ", {31'h0, nMREQ}, 32'h0);
            check_val("ws_hold_mas", {30'h0, mas}, 32'h2);
        end
        nWAIT = 1'b1;
        tick();
        check_val("ws_A14", A, 32'h14);
        check_val("ws_head", instrPC, 32'hC);
        decodeReady = 1'b1;
        tick();
        check_val("ws_pc10", instrPC, 32'h10);
        tick();
        check_val("ws_pc14", instrPC, 32'h14);

        // Thumb halfwords after a redirect
        branchValid = 1'b1; branchTarget = 32'h102; tbit = 1'b1;
        use_fixed = 1'b1; d_fixed = 32'hAAAA_BBBB;
        tick();
        branchValid = 1'b0;
        check_val("th_A", A, 32'h102);
        check_val("th_seq0", {31'h0, seq}, 32'h0);
        check_val("th_valid0", {31'h0, instrValid}, 32'h0);
        check_val("th_mas", {30'h0, mas}, 32'h1);
        tick();
        check_val("th_d_hi", instrData, 32'h0000_AAAA);
        check_val("th_pc", instrPC, 32'h102);
        check_val("th_A104", A, 32'h104);
        check_val("th_seq1", {31'h0, seq}, 32'h1);
        tick();
        check_val("th_d_lo", instrData, 32'h0000_BBBB);
        check_val("th_A106", A, 32'h106);

        // Redirect while the bus is stalled
        tbit = 1'b0; use_fixed = 1'b0; decodeReady = 1'b0;
        do_reset();
        tick(); tick();
        check_val("rw_full", {31'h0, instrValid}, 32'h1);
        nWAIT = 1'b0; branchValid = 1'b1; branchTarget = 32'h203;
        tick();
        branchValid = 1'b0;
        check_val("rw_flush", {31'h0, instrValid}, 32'h0);
        check_val("rw_frozen_A", A, 32'h8);
        tick();
        check_val("rw_frozen_A2", A, 32'h8);
        check_val("rw_empty", {31'h0, instrValid}, 32'h0);
        nWAIT = 1'b1;
        tick();
        check_val("rw_A200", A, 32'h200);
        check_val("rw_seq0", {31'h0, seq}, 32'h0);
        check_val("rw_discard", {31'h0, instrValid}, 32'h0);
        tick();
        check_val("rw_pc", instrPC, 32'h200);
        check_val("rw_d", instrData, 32'h1234_5478);
        check_val("rw_A204", A, 32'h204);

        // Abort and address wrap
        decodeReady = 1'b1; branchValid = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick();
        branchValid = 1'b0;
        check_val("ab_A", A, 32'hFFFF_FFFC);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("ab_flag", {31'h0, instrAbort}, 32'h1);
        check_val("ab_pc", instrPC, 32'hFFFF_FFFC);
        check_val("ab_d", instrData, 32'hEDCB_A984);
        check_val("ab_wrapA", A, 32'h0);
        check_val("ab_seq", {31'h0, seq}, 32'h1);
        tick();
        check_val("ab_next_flag", {31'h0, instrAbort}, 32'h0);
        check_val("ab_next_pc", instrPC, 32'h0);

        // Reset in the middle of fetching
        reset = 1'b1;
        tick();
        check_val("mr_valid", {31'h0, instrValid}, 32'h0);
        check_val("mr_nMREQ", {31'h0, nMREQ}, 32'h1);
        check_val("mr_A", A, 32'h0);
        reset = 1'b0;
        tick();
        check_val("mr_A4", A, 32'h4);
        check_val("mr_pc0", instrPC, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
